id_ex_stage: RTL and testbench

Decode-side pipeline stage sitting directly downstream of the register file in the 5-stage MIPS pipeline. Captures register-file read data and decoded controls into the ID/EX pipeline register. Detects load-use and branch-operand hazards and generates the fetch/decode stall. Resolves `beq` in decode, with operand forwarding from the MEM stage.

---
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-side stage of the 5-stage MIPS pipeline.
// It holds the ID/EX pipeline register and detects load-use and branch-operand
// hazards. It also resolves beq in decode, forwarding branch operands from MEM.
// Optional feature: define ID_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic        reg_write_d,
    input  logic        mem_to_reg_d,
    input  logic        mem_write_d,
    input  logic        alu_src_d,
    input  logic        reg_dst_d,
    input  logic        branch_d,
    input  logic [2:0]  alu_ctrl_d,
    input  logic [4:0]  write_reg_e,
    input  logic [4:0]  write_reg_m,
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic [31:0] alu_out_m,
    output logic        stall_f,
    output logic        stall_d,
    output logic        pc_src_d,
    output logic [31:0] pc_branch_d,
    output logic        reg_write_e,
    output logic        mem_to_reg_e,
    output logic        mem_write_e,
    output logic        alu_src_e,
    output logic        reg_dst_e,
    output logic [2:0]  alu_ctrl_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] sign_imm_e,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
`ifdef ID_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic [4:0]  rd_e
);

    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic [31:0] sign_imm_d;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        lw_stall;
    logic        branch_stall;
    logic        stall;
    logic        unused_opcode;

    // The opcode bits are decoded by the control unit, not here
    assign unused_opcode = &{1'b0, instr_d[31:26]};

    // Decode the instruction fields and form the branch target
    always_comb begin
        rs_d        = instr_d[25:21];
        rt_d        = instr_d[20:16];
        rd_d        = instr_d[15:11];
        sign_imm_d  = {{16{instr_d[15]}}, instr_d[15:0]};
        pc_branch_d = pc_plus4_d + {sign_imm_d[29:0], 2'b00};
    end

    // Branch comparator operands, with MEM-stage results bypassing stale register data
    always_comb begin
        op_a = rd1_d;
        op_b = rd2_d;
        if (reg_write_m && (rs_d != 5'd0) && (rs_d == write_reg_m))
            op_a = alu_out_m;
        if (reg_write_m && (rt_d != 5'd0) && (rt_d == write_reg_m))
            op_b = alu_out_m;
    end

    // Hazard detection: a load in EX feeding decode, or a branch whose operands are not ready
    always_comb begin
        lw_stall     = mem_to_reg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));
        branch_stall = branch_d &&
                       ((reg_write_e && (write_reg_e != 5'd0) &&
                         ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                        (mem_to_reg_m && (write_reg_m != 5'd0) &&
                         ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
        stall        = lw_stall || branch_stall;
        stall_f      = stall;
        stall_d      = stall;
        pc_src_d     = branch_d && (op_a == op_b) && !stall;
    end

    // ID/EX pipeline register: a stall inserts an all-zero bubble instead of the decode values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            mem_write_e  <= 1'b0;
            alu_src_e    <= 1'b0;
            reg_dst_e    <= 1'b0;
            alu_ctrl_e   <= 3'd0;
            rd1_e        <= 32'd0;
            rd2_e        <= 32'd0;
            sign_imm_e   <= 32'd0;
            rs_e         <= 5'd0;
            rt_e         <= 5'd0;
            rd_e         <= 5'd0;
        end else if (stall) begin
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            mem_write_e  <= 1'b0;
            alu_src_e    <= 1'b0;
            reg_dst_e    <= 1'b0;
            alu_ctrl_e   <= 3'd0;
            rd1_e        <= 32'd0;
            rd2_e        <= 32'd0;
            sign_imm_e   <= 32'd0;
            rs_e         <= 5'd0;
            rt_e         <= 5'd0;
            rd_e         <= 5'd0;
        end else begin
            reg_write_e  <= reg_write_d;
            mem_to_reg_e <= mem_to_reg_d;
            mem_write_e  <= mem_write_d;
            alu_src_e    <= alu_src_d;
            reg_dst_e    <= reg_dst_d;
            alu_ctrl_e   <= alu_ctrl_d;
            rd1_e        <= rd1_d;
            rd2_e        <= rd2_d;
            sign_imm_e   <= sign_imm_d;
            rs_e         <= rs_d;
            rt_e         <= rt_d;
            rd_e         <= rd_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    // Count stalled cycles, sticking at the maximum rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'd0;
        else if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a reference model.
// Define ID_STALL_CNT_EN to also exercise the stall counter.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d, pc_plus4_d, rd1_d, rd2_d, alu_out_m;
    logic        reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d, branch_d;
    logic [2:0]  alu_ctrl_d;
    logic [4:0]  write_reg_e, write_reg_m;
    logic        reg_write_m, mem_to_reg_m;
    logic        stall_f, stall_d, pc_src_d;
    logic [31:0] pc_branch_d;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
    logic [2:0]  alu_ctrl_e;
    logic [31:0] rd1_e, rd2_e, sign_imm_e;
    logic [4:0]  rs_e, rt_e, rd_e;
`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Expected contents of the ID/EX register
    typedef struct packed {
        logic        rw, m2r, mw, asrc, rdst;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, simm;
        logic [4:0]  rs, rt, rd;
    } ex_t;

    ex_t mdl;
    int  mdl_cnt;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
        .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
        .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d), .write_reg_e(write_reg_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .alu_out_m(alu_out_m), .stall_f(stall_f), .stall_d(stall_d), .pc_src_d(pc_src_d),
        .pc_branch_d(pc_branch_d), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .alu_ctrl_e(alu_ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e),
        .rs_e(rs_e), .rt_e(rt_e),
`ifdef ID_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .rd_e(rd_e)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkI(logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {6'b000100, rs, rt, imm};
    endfunction

    // Reference: does the current decode cycle stall?
    function automatic bit mdlStall();
        int rs, rt;
        bit lw, br_e, br_m;
        rs = int'(instr_d[25:21]);
        rt = int'(instr_d[20:16]);
        lw   = mdl.m2r && mdl.rt != 0 && (int'(mdl.rt) == rs || int'(mdl.rt) == rt);
        br_e = reg_write_e_src() && write_reg_e != 0 &&
               (int'(write_reg_e) == rs || int'(write_reg_e) == rt);
        br_m = mem_to_reg_m && write_reg_m != 0 &&
               (int'(write_reg_m) == rs || int'(write_reg_m) == rt);
        return lw || (branch_d && (br_e || br_m));
    endfunction

    function automatic bit reg_write_e_src();
        return mdl.rw;
    endfunction

    // Reference: branch operand value seen by the comparator
    function automatic logic [31:0] mdlOperand(logic [4:0] r, logic [31:0] rf);
        if (r != 0 && r == write_reg_m && reg_write_m) return alu_out_m;
        return rf;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(logic [31:0] instr, logic [31:0] pc4, logic [31:0] r1,
                                 logic [31:0] r2, logic [5:0] ctl, logic [2:0] alu,
                                 logic [4:0] wre, logic [4:0] wrm, logic rwm, logic m2rm,
                                 logic [31:0] aom);
        instr_d = instr; pc_plus4_d = pc4; rd1_d = r1; rd2_d = r2;
        {reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d, branch_d} = ctl;
        alu_ctrl_d = alu; write_reg_e = wre; write_reg_m = wrm;
        reg_write_m = rwm; mem_to_reg_m = m2rm; alu_out_m = aom;
        #1;
    endtask

    // Combinational outputs against the model
    task automatic checkOutput(string tag);
        logic [31:0] tgt;
        bit st, taken;
        st    = mdlStall();
        tgt   = pc_plus4_d + 32'(int'($signed(instr_d[15:0])) * 4);
        taken = branch_d && !st &&
                (mdlOperand(instr_d[25:21], rd1_d) == mdlOperand(instr_d[20:16], rd2_d));
        chk({tag, ".stall_f"}, 32'(stall_f), 32'(st));
        chk({tag, ".stall_d"}, 32'(stall_d), 32'(st));
        chk({tag, ".pc_src"}, 32'(pc_src_d), 32'(taken));
        chk({tag, ".pc_branch"}, pc_branch_d, tgt);
    endtask

    task automatic checkRegs(string tag);
        chk({tag, ".reg_write_e"}, 32'(reg_write_e), 32'(mdl.rw));
        chk({tag, ".mem_to_reg_e"}, 32'(mem_to_reg_e), 32'(mdl.m2r));
        chk({tag, ".mem_write_e"}, 32'(mem_write_e), 32'(mdl.mw));
        chk({tag, ".alu_src_e"}, 32'(alu_src_e), 32'(mdl.asrc));
        chk({tag, ".reg_dst_e"}, 32'(reg_dst_e), 32'(mdl.rdst));
        chk({tag, ".alu_ctrl_e"}, 32'(alu_ctrl_e), 32'(mdl.alu));
        chk({tag, ".rd1_e"}, rd1_e, mdl.rd1);
        chk({tag, ".rd2_e"}, rd2_e, mdl.rd2);
        chk({tag, ".sign_imm_e"}, sign_imm_e, mdl.simm);
        chk({tag, ".rs_e"}, 32'(rs_e), 32'(mdl.rs));
        chk({tag, ".rt_e"}, 32'(rt_e), 32'(mdl.rt));
        chk({tag, ".rd_e"}, 32'(rd_e), 32'(mdl.rd));
`ifdef ID_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mdl_cnt));
`endif
    endtask

    // One rising edge: advance the model, then compare the registered outputs
    task automatic stepCycle(string tag, bit do_check);
        ex_t nxt;
        bit st;
        st  = mdlStall();
        nxt = '0;
        if (!st) begin
            nxt.rw = reg_write_d; nxt.m2r = mem_to_reg_d; nxt.mw = mem_write_d;
            nxt.asrc = alu_src_d; nxt.rdst = reg_dst_d; nxt.alu = alu_ctrl_d;
            nxt.rd1 = rd1_d; nxt.rd2 = rd2_d;
            nxt.simm = 32'(int'($signed(instr_d[15:0])));
            nxt.rs = instr_d[25:21]; nxt.rt = instr_d[20:16]; nxt.rd = instr_d[15:11];
        end
        @(posedge clk);
        if (rst_n) begin
            mdl = nxt;
            if (st && mdl_cnt < 65535) mdl_cnt++;
        end
        #1;
        if (do_check) checkRegs(tag);
    endtask

    initial begin
        logic [31:0] ins;
        mdl = '0;
        mdl_cnt = 0;
        rst_n = 1'b0;

        // Reset state with random inputs present
        applyStimulus($urandom, $urandom, $urandom, $urandom, 6'($urandom), 3'($urandom),
                      5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), $urandom);
        checkRegs("reset");
        stepCycle("reset_hold", 1);
        #2 rst_n = 1'b1;

        // Load-use: lw into EX, then add reading its target
        applyStimulus(mkI(5'd1, 5'd5, 16'h0010), 32'h40, 32'h1, 32'h2, 6'b110000, 3'd2,
                      5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("lu_lw");
        stepCycle("lu_lw", 1);
        applyStimulus(mkI(5'd5, 5'd6, {5'd7, 11'h020}), 32'h44, 32'h33, 32'h44, 6'b100000,
                      3'd2, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("lu_add");
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_stall_d", 32'(stall_d), 32'd1);
        stepCycle("lu_bubble", 1);
        chk("lu_bubble_rw", 32'(reg_write_e), 32'd0);
        chk("lu_bubble_rd1", rd1_e, 32'd0);
        checkOutput("lu_release");
        chk("lu_release_stall", 32'(stall_f), 32'd0);
        stepCycle("lu_capture", 1);
        chk("lu_capture_rs", 32'(rs_e), 32'd5);
        chk("lu_capture_rd", 32'(rd_e), 32'd7);
        chk("lu_capture_rd1", rd1_e, 32'h33);

        // beq with rt forwarded from MEM, taken, negative offset
        applyStimulus(mkI(5'd3, 5'd4, 16'hFFFF), 32'h100, 32'd7, 32'd9, 6'b000001, 3'd6,
                      5'd0, 5'd4, 1'b1, 1'b0, 32'd7);
        checkOutput("memfwd");
        chk("memfwd_pc_src", 32'(pc_src_d), 32'd1);
        chk("memfwd_target", pc_branch_d, 32'h000000FC);
        stepCycle("memfwd", 1);

        // beq depending on an ALU producer in EX, then in MEM
        applyStimulus(mkI(5'd1, 5'd2, 16'h0), 32'h1F0, 32'h5, 32'h5, 6'b100000, 3'd2,
                      5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("exprod_setup");
        stepCycle("exprod_setup", 1);
        applyStimulus(mkI(5'd2, 5'd6, 16'h0004), 32'h200, 32'h11, 32'h22, 6'b000001, 3'd6,
                      5'd2, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("exprod_ex");
        chk("exprod_ex_stall", 32'(stall_d), 32'd1);
        chk("exprod_ex_pc_src", 32'(pc_src_d), 32'd0);
        stepCycle("exprod_bubble", 1);
        applyStimulus(mkI(5'd2, 5'd6, 16'h0004), 32'h200, 32'h11, 32'h22, 6'b000001, 3'd6,
                      5'd0, 5'd2, 1'b1, 1'b0, 32'h22);
        checkOutput("exprod_mem");
        chk("exprod_mem_stall", 32'(stall_d), 32'd0);
        chk("exprod_mem_pc_src", 32'(pc_src_d), 32'd1);
        chk("exprod_mem_target", pc_branch_d, 32'h210);
        stepCycle("exprod_mem", 1);

        // Register 0 never stalls
        applyStimulus(mkI(5'd1, 5'd0, 16'h0), 32'h0, 32'h0, 32'h0, 6'b110000, 3'd2,
                      5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        stepCycle("r0_setup", 1);
        applyStimulus(mkI(5'd0, 5'd0, 16'h1234), 32'h300, 32'h0, 32'h0, 6'b100000, 3'd2,
                      5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("r0");
        chk("r0_stall", 32'(stall_f), 32'd0);
        stepCycle("r0_capture", 1);
        chk("r0_capture_imm", sign_imm_e, 32'h1234);

        // Reset asserted in the middle of a load-use stall
        applyStimulus(mkI(5'd2, 5'd5, 16'h0), 32'h0, 32'h0, 32'h0, 6'b110000, 3'd2,
                      5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        stepCycle("rstmid_setup", 1);
        applyStimulus(mkI(5'd5, 5'd3, 16'h8000), 32'h400, 32'hAAAA, 32'hBBBB, 6'b100000,
                      3'd2, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
        chk("rstmid_stall", 32'(stall_f), 32'd1);
        #2 rst_n = 1'b0;
        mdl = '0;
        mdl_cnt = 0;
        #1;
        checkRegs("rstmid_async");
        #1 rst_n = 1'b1;
        stepCycle("rstmid_release", 1);
        chk("rstmid_rs", 32'(rs_e), 32'd5);
        chk("rstmid_imm", sign_imm_e, 32'hFFFF8000);
        chk("rstmid_rd1", rd1_e, 32'hAAAA);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            applyStimulus(ins, $urandom,
                          ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                          ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                          6'($urandom), 3'($urandom),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 32'($urandom_range(0, 3)));
            checkOutput("rand");
            stepCycle("rand", 1);
        end

`ifdef ID_STALL_CNT_EN
        // Hold a branch stall long enough to saturate the counter
        applyStimulus(mkI(5'd1, 5'd2, 16'h0), 32'h0, 32'h0, 32'h0, 6'b000001, 3'd0,
                      5'd0, 5'd1, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 70000; i++) stepCycle("cnt", 0);
        chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
        checkRegs("cnt_sat");
        for (int i = 0; i < 3; i++) stepCycle("cnt_hold", 1);
        chk("cnt_hold", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
